// File: rtl/irq_ctrl.sv
// Interrupt controller: per-line rising-edge capture into pending, maskable
// lowest-index selection, req/ack CPU handshake and a four-register port.
//
// state | meaning
// IDLE  | no request outstanding, scanning pending & mask
// REQ   | irq_req high, irq_vec frozen until irq_ack
// GAP   | one dead cycle after ack, clears the in-service bit
module irq_ctrl #(
   parameter int          NIRQ      = 32,
   parameter logic [31:0] MASK_INIT = 32'hFFFF_FFFF,
   parameter int          VECW      = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NIRQ-1:0] irqs,
   output logic            irq_req,
   output logic [VECW-1:0] irq_vec,
   input  logic            irq_ack,
   input  logic            strobe,
   input  logic            rw,
   input  logic [1:0]      addr,
   input  logic [31:0]     d_in,
   output logic [31:0]     d_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t          state;
   logic [NIRQ-1:0] prev_irqs;
   logic [NIRQ-1:0] pending;
   logic [NIRQ-1:0] mask;
   logic [NIRQ-1:0] inservice;
   logic [15:0]     drops;

   logic [NIRQ-1:0] edges;
   logic [NIRQ-1:0] active;
   logic [NIRQ-1:0] ack_clr;
   logic [NIRQ-1:0] w1c_clr;
   logic [NIRQ-1:0] clr;
   logic [NIRQ-1:0] drop_vec;
   logic [5:0]      drop_cnt;
   logic [16:0]     drop_sum;
   logic [VECW-1:0] low_idx;
   logic            wr_pend;
   logic            wr_mask;
   logic            wr_drops;
   logic            rd;
   logic            ack_take;

   assign wr_pend  = strobe && rw && (addr == 2'd0);
   assign wr_mask  = strobe && rw && (addr == 2'd1);
   assign wr_drops = strobe && rw && (addr == 2'd3);
   assign rd       = strobe && !rw;
   assign ack_take = (state == REQ) && irq_ack;

   assign edges   = irqs & ~prev_irqs;
   assign active  = pending & mask;
   assign ack_clr = ack_take ? (NIRQ'(1) << irq_vec) : '0;
   assign w1c_clr = wr_pend ? d_in[NIRQ-1:0] : '0;
   assign clr     = ack_clr | w1c_clr;
   // A bit being cleared this cycle takes the new edge as fresh, not a drop.
   assign drop_vec = edges & pending & ~clr;

   always_comb begin
      drop_cnt = '0;
      for (int i = 0; i < NIRQ; i++) begin
         drop_cnt = drop_cnt + 6'(drop_vec[i]);
      end
   end

   always_comb begin
      low_idx = '0;
      for (int i = NIRQ - 1; i >= 0; i--) begin
         if (active[i]) low_idx = VECW'(i);
      end
   end

   assign drop_sum = (wr_drops ? 17'd0 : {1'b0, drops}) + 17'(drop_cnt);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_irqs <= '0;
         pending   <= '0;
         mask      <= MASK_INIT[NIRQ-1:0];
         drops     <= '0;
         d_out     <= '0;
      end else begin
         prev_irqs <= irqs;
         pending   <= (pending & ~clr) | edges;
         drops     <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
         if (wr_mask) mask <= d_in[NIRQ-1:0];
         if (rd) begin
            case (addr)
               2'd0: d_out <= 32'(pending);
               2'd1: d_out <= 32'(mask);
               2'd2: d_out <= 32'(inservice);
               2'd3: d_out <= {16'h0, drops};
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         irq_req   <= 1'b0;
         irq_vec   <= '0;
         inservice <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (active != '0) begin
                  irq_vec   <= low_idx;
                  inservice <= NIRQ'(1) << low_idx;
                  irq_req   <= 1'b1;
                  state     <= REQ;
               end
            end
            REQ: begin
               if (irq_ack) begin
                  irq_req <= 1'b0;
                  state   <= GAP;
               end
            end
            GAP: begin
               inservice <= '0;
               state     <= IDLE;
            end
            default: begin
               irq_req <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus a randomized run, all checked
// against a cycle-level behavioural model of the controller kept here.
module tb_irq_ctrl;

   logic        clk;
   logic        reset;
   logic [31:0] irqs;
   logic        irq_req;
   logic [4:0]  irq_vec;
   logic        irq_ack;
   logic        strobe;
   logic        rw;
   logic [1:0]  addr;
   logic [31:0] d_in;
   logic [31:0] d_out;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   irq_ctrl #(.NIRQ(32), .MASK_INIT(32'hFFFF_FFFF), .VECW(5)) dut (
      .clk(clk), .reset(reset), .irqs(irqs), .irq_req(irq_req),
      .irq_vec(irq_vec), .irq_ack(irq_ack), .strobe(strobe), .rw(rw),
      .addr(addr), .d_in(d_in), .d_out(d_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural reference: pending/mask as words, service as a phase number
   // (0 waiting, 1 requesting, 2 dead cycle), drops as a plain saturating int.
   logic [31:0] m_pend, m_mask, m_prev, m_isv, m_dout;
   logic [31:0] e_edges, e_clr, e_act;
   logic        m_req;
   logic [4:0]  m_vec;
   int          m_drops, m_phase, e_nd, e_base;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_pend = 0; m_mask = 32'hFFFF_FFFF; m_prev = 0; m_isv = 0; m_dout = 0;
         m_req = 0; m_vec = 0; m_drops = 0; m_phase = 0;
      end else begin
         e_edges = irqs & ~m_prev;
         e_clr = 0;
         if (strobe && rw && addr == 2'd0) e_clr = d_in;
         if (m_phase == 1 && irq_ack) e_clr[m_vec] = 1'b1;
         e_nd = 0;
         for (int i = 0; i < 32; i++)
            if (e_edges[i] && m_pend[i] && !e_clr[i]) e_nd++;
         e_base = (strobe && rw && addr == 2'd3) ? 0 : m_drops;
         if (strobe && !rw) begin
            if (addr == 2'd0) m_dout = m_pend;
            else if (addr == 2'd1) m_dout = m_mask;
            else if (addr == 2'd2) m_dout = m_isv;
            else m_dout = 32'(m_drops);
         end
         e_act = m_pend & m_mask;
         if (m_phase == 0) begin
            if (e_act != 0) begin
               for (int i = 31; i >= 0; i--) if (e_act[i]) m_vec = 5'(i);
               m_isv = 32'h1 << m_vec;
               m_req = 1;
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (irq_ack) begin m_req = 0; m_phase = 2; end
         end else begin
            m_isv = 0;
            m_phase = 0;
         end
         if (strobe && rw && addr == 2'd1) m_mask = d_in;
         m_pend = (m_pend & ~e_clr) | e_edges;
         m_drops = (e_base + e_nd > 65535) ? 65535 : e_base + e_nd;
         m_prev = irqs;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      reset = 0; irqs = 0; irq_ack = 0; strobe = 0; rw = 0; addr = 0; d_in = 0;
      tick(2);
      reset = 1;
      tick(1);
   endtask

   task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
      strobe = 1; rw = 0; addr = a;
      tick();
      strobe = 0;
      d = d_out;
   endtask

   task automatic write_reg(input logic [1:0] a, input logic [31:0] v);
      strobe = 1; rw = 1; addr = a; d_in = v;
      tick();
      strobe = 0; rw = 0;
   endtask

   task automatic wait_req(input int max, output int n);
      n = 0;
      while (!irq_req && n < max) begin tick(); n++; end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      do_reset();
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", irq_req); end
      checks++; if (irq_vec !== 5'd0) begin errors++; $display("FAIL rst_vec: got %0d exp 0", irq_vec); end
      checks++; if (d_out !== 32'h0) begin errors++; $display("FAIL rst_dout: got %h exp 0", d_out); end
      read_reg(2'd0, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_pending: got %h exp 0", d); end
      read_reg(2'd1, d);
      checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_mask: got %h exp ffffffff", d); end
      read_reg(2'd2, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_inservice: got %h exp 0", d); end
      read_reg(2'd3, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_drops: got %h exp 0", d); end
   endtask

   task automatic test_single();
      logic [31:0] d;
      do_reset();
      irqs = 32'h8;
      tick();
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL single_early: got %b exp 0", irq_req); end
      tick();
      irqs = 0;
      checks++; if (irq_req !== 1'b1 || irq_vec !== 5'd3) begin errors++; $display("FAIL single_req: got req=%b vec=%0d exp req=1 vec=3", irq_req, irq_vec); end
      read_reg(2'd2, d);
      checks++; if (d !== 32'h8) begin errors++; $display("FAIL single_insvc: got %h exp 8", d); end
      irq_ack = 1;
      tick();
      irq_ack = 0;
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL single_drop: got %b exp 0", irq_req); end
      read_reg(2'd0, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL single_pending: got %h exp 0", d); end
      read_reg(2'd2, d);
      checks++; if (d !== 32'h0 || d !== m_dout) begin errors++; $display("FAIL single_insvc_gap: got %h exp 0", d); end
   endtask

   task automatic test_priority();
      int n, t1;
      do_reset();
      irqs = 32'h84;
      tick();
      irqs = 0;
      wait_req(5, n);
      t1 = cyc;
      checks++; if (irq_req !== 1'b1 || irq_vec !== 5'd2) begin errors++; $display("FAIL prio_first: got req=%b vec=%0d exp req=1 vec=2", irq_req, irq_vec); end
      irq_ack = 1;
      tick();
      irq_ack = 0;
      wait_req(10, n);
      checks++; if (irq_req !== 1'b1 || irq_vec !== 5'd7) begin errors++; $display("FAIL prio_second: got req=%b vec=%0d exp req=1 vec=7", irq_req, irq_vec); end
      checks++; if (cyc - t1 != 3) begin errors++; $display("FAIL prio_spacing: got %0d exp 3", cyc - t1); end
      irq_ack = 1;
      tick();
      irq_ack = 0;
   endtask

   task automatic test_mask();
      logic [31:0] d;
      do_reset();
      write_reg(2'd1, 32'hFFFF_FFFB);
      irqs = 32'h4;
      tick();
      irqs = 0;
      tick(3);
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL mask_blocked: got %b exp 0", irq_req); end
      read_reg(2'd0, d);
      checks++; if (d !== 32'h4) begin errors++; $display("FAIL mask_pending: got %h exp 4", d); end
      write_reg(2'd1, 32'hFFFF_FFFF);
      tick();
      checks++; if (irq_req !== 1'b1 || irq_vec !== 5'd2) begin errors++; $display("FAIL mask_release: got req=%b vec=%0d exp req=1 vec=2", irq_req, irq_vec); end
   endtask

   task automatic test_drops();
      logic [31:0] d;
      int n;
      do_reset();
      irqs = 32'h20; tick(); irqs = 0; tick();
      irqs = 32'h20; tick(); irqs = 0; tick();
      read_reg(2'd3, d);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL drops_one: got %h exp 1", d); end
      checks++; if (irq_req !== 1'b1 || irq_vec !== 5'd5) begin errors++; $display("FAIL drops_req: got req=%b vec=%0d exp req=1 vec=5", irq_req, irq_vec); end
      irq_ack = 1; tick(); irq_ack = 0;
      tick(4);
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL drops_single_service: got %b exp 0", irq_req); end
      write_reg(2'd3, 32'h0);
      read_reg(2'd3, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL drops_clear: got %h exp 0", d); end
      irqs = 32'h20; tick(); irqs = 0; tick();
      strobe = 1; rw = 1; addr = 2'd3; d_in = 32'h0; irqs = 32'h20;
      tick();
      strobe = 0; rw = 0; irqs = 0;
      read_reg(2'd3, d);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL drops_write_and_drop: got %h exp 1", d); end
      for (int k = 0; k < 2200; k++) begin
         irqs = 32'hFFFF_FFFF; tick(); irqs = 0; tick();
      end
      read_reg(2'd3, d);
      checks++; if (d !== 32'h0000_FFFF || m_drops != 65535) begin errors++; $display("FAIL drops_saturate: got %h exp ffff", d); end
      wait_req(2, n);
      irq_ack = 1; tick(); irq_ack = 0;
      write_reg(2'd0, 32'hFFFF_FFFF);
   endtask

   task automatic test_set_beats_clear();
      logic [31:0] d;
      int n;
      do_reset();
      irqs = 32'h10; tick(); irqs = 0;
      wait_req(5, n);
      checks++; if (irq_req !== 1'b1 || irq_vec !== 5'd4) begin errors++; $display("FAIL sbc_req: got req=%b vec=%0d exp req=1 vec=4", irq_req, irq_vec); end
      irq_ack = 1; irqs = 32'h10;
      tick();
      irq_ack = 0; irqs = 0;
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL sbc_ack: got %b exp 0", irq_req); end
      read_reg(2'd0, d);
      checks++; if (d !== 32'h10) begin errors++; $display("FAIL sbc_pending: got %h exp 10", d); end
      wait_req(10, n);
      checks++; if (irq_req !== 1'b1 || irq_vec !== 5'd4) begin errors++; $display("FAIL sbc_rerequest: got req=%b vec=%0d exp req=1 vec=4", irq_req, irq_vec); end
      read_reg(2'd3, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL sbc_drops: got %h exp 0", d); end
      irq_ack = 1; tick(); irq_ack = 0;
      tick(3);
      write_reg(2'd1, 32'hFFFF_FFEF);
      irqs = 32'h10; tick(); irqs = 0; tick();
      strobe = 1; rw = 1; addr = 2'd0; d_in = 32'h10; irqs = 32'h10;
      tick();
      strobe = 0; rw = 0; irqs = 0;
      read_reg(2'd0, d);
      checks++; if (d !== 32'h10) begin errors++; $display("FAIL sbc_w1c_pending: got %h exp 10", d); end
      read_reg(2'd3, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL sbc_w1c_drops: got %h exp 0", d); end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 1500; k++) begin
         irqs = $urandom & $urandom & $urandom;
         irq_ack = ($urandom_range(0, 2) == 0);
         strobe = ($urandom_range(0, 3) == 0);
         rw = $urandom_range(0, 1);
         addr = 2'($urandom_range(0, 3));
         d_in = (addr == 2'd1) ? ($urandom | $urandom) : $urandom;
         tick();
         checks++; if (irq_req !== m_req) begin errors++; if (errors < 20) $display("FAIL rnd_req cyc %0d: got %b exp %b", cyc, irq_req, m_req); end
         checks++; if (irq_vec !== m_vec) begin errors++; if (errors < 20) $display("FAIL rnd_vec cyc %0d: got %0d exp %0d", cyc, irq_vec, m_vec); end
         checks++; if (d_out !== m_dout) begin errors++; if (errors < 20) $display("FAIL rnd_dout cyc %0d: got %h exp %h", cyc, d_out, m_dout); end
      end
      irqs = 0; irq_ack = 0; strobe = 0; rw = 0;
   endtask

   task automatic test_reset_mid_req();
      logic [31:0] d;
      int n;
      do_reset();
      irqs = 32'h200; tick(); irqs = 0;
      wait_req(5, n);
      checks++; if (irq_req !== 1'b1 || irq_vec !== 5'd9) begin errors++; $display("FAIL rmid_req: got req=%b vec=%0d exp req=1 vec=9", irq_req, irq_vec); end
      write_reg(2'd1, 32'h0000_0F00);
      #2 reset = 0;
      #1;
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL rmid_async: got %b exp 0", irq_req); end
      tick();
      reset = 1;
      tick(3);
      checks++; if (irq_req !== 1'b0 || irq_vec !== 5'd0) begin errors++; $display("FAIL rmid_after: got req=%b vec=%0d exp req=0 vec=0", irq_req, irq_vec); end
      read_reg(2'd0, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rmid_pending: got %h exp 0", d); end
      read_reg(2'd1, d);
      checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rmid_mask: got %h exp ffffffff", d); end
      read_reg(2'd3, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rmid_drops: got %h exp 0", d); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_mask();
      test_drops();
      test_set_beats_clear();
      test_random();
      test_reset_mid_req();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Receiving end of the 32-bit `irqs` interrupt vector that the simulation top (and later board tops) drives into the core.
- Detects rising edges on each line, latches them as pending, applies a mask and selects the lowest-numbered active source.
- Presents that source to the CPU with a req/ack handshake.
- Exposes pending, mask, in-service and drop-count registers on a small memory-mapped port for the interrupt handler.

Parameters:
- NIRQ, 32, number of interrupt lines (1..32); bits at and above NIRQ read as zero.
- MASK_INIT, 32'hFFFFFFFF, reset value of the mask register (1 = enabled).
- VECW, 5, width of the vector output; must satisfy 2**VECW >= NIRQ.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserting it (0) clears all state immediately
- irqs  in  NIRQ  interrupt lines, synchronous to clk, active-high; edge-triggered
- irq_req  out  1  interrupt request to CPU
- irq_vec  out  VECW  index of the requested source; valid while irq_req=1
- irq_ack  in  1  CPU accepts the request; sampled only while irq_req=1
- strobe  in  1  register-port access strobe
- rw  in  1  1 = write, 0 = read
- addr  in  2  register select: 0 PENDING, 1 MASK, 2 INSERVICE, 3 DROPS
- d_in  in  32  write data
- d_out  out  32  read data, registered

Behaviour:
- Reset (reset=0, async) values:
  - irq_req=0, irq_vec=0, d_out=0
  - pending=0, mask=MASK_INIT, prev_irqs=0, drops=0
  - FSM=IDLE, inservice=32'h0
- Edge detect:
  - prev_irqs <= irqs every cycle.
  - An edge on bit i is irqs[i] & ~prev_irqs[i]; it sets pending[i] on the same clock edge.
  - A level held high produces exactly one edge.
- Drop counting:
  - An edge on bit i while pending[i] is already 1 increments drops by 1 (16-bit, saturating at 16'hFFFF).
  - Multiple simultaneous drops add their count, saturating.
- Active set: active = pending & mask. Selection is always the lowest set index of active.
- FSM:
  - IDLE: if active != 0, latch irq_vec = lowest active index, set inservice bit, go REQ (irq_req=1 from the next cycle).
  - REQ: irq_req=1, irq_vec held stable regardless of later pending/mask changes.
    - Mask changes do not withdraw the request.
    - On irq_ack=1: clear pending[irq_vec], go GAP, irq_req=0 next cycle.
  - GAP: one idle cycle; clear the inservice bit; go IDLE.
  - irq_ack outside REQ is ignored.
- Latency:
  - Edge first sampled at clock edge k sets pending at k.
  - FSM leaves IDLE at edge k+1, so irq_req is high after edge k+1.
  - Back-to-back service: minimum 3 cycles between successive irq_req rising edges.
- Simultaneous events on one bit in one cycle:
  - Set beats clear: a new edge on bit i coincides with ack of i or a W1C of bit i → pending[i] stays 1 and no drop is counted.
  - Edge on the bit being acked counts as a fresh interrupt, not a drop.
- Register port: write takes effect at the clock edge with strobe=1, rw=1.
  - PENDING, addr 0: read pending; write-1-to-clear.
    - Clearing the bit currently in REQ does not withdraw the request.
  - MASK, addr 1: read/write.
  - INSERVICE, addr 2: read-only, one-hot of the source in REQ/GAP, else 0.
  - DROPS, addr 3: read zero-extended drops; any write clears it to 0.
    - A write and a drop in the same cycle leave drops=1.
  - Read: strobe=1, rw=0 at edge k → d_out valid after edge k, held until the next read.
- NIRQ < 32: unused pending/mask bits are constant 0; writes to them are ignored.
- Reset asserted mid-REQ drops irq_req asynchronously; after release no pending state survives.

Test Plan:
- Reset release, pulse irqs[3] high for 2 cycles at cycle 10 → irq_req=1 from cycle 12 with irq_vec=3; ack at cycle 14 → irq_req=0 at 15, PENDING reads 0, INSERVICE reads 0 after GAP.
- irqs[7] and irqs[2] rise in the same cycle → first irq_vec=2; after ack, next irq_vec=7, with irq_req rising edges exactly 3 cycles apart when ack is immediate.
- Write MASK=32'hFFFFFFFB, pulse irqs[2] → no irq_req, PENDING=32'h4; write MASK=32'hFFFFFFFF → irq_req next cycle, irq_vec=2.
- Pulse irqs[5] twice before ack → DROPS=1, one service only; write DROPS → reads 0; 70000 drops → reads 16'hFFFF.
- While in REQ on vec 4: rising edge on irqs[4] in the ack cycle → pending[4] remains 1, second request for 4 follows, DROPS unchanged.
- Assert reset (0) mid-REQ → irq_req falls without waiting for clk; after release, PENDING=0, MASK=MASK_INIT, DROPS=0, irq_vec=0.
